// File: rtl/corner_win_sequencer.sv
// Frame sequencer for a two-window corner detector. It streams one frame of pixels, then flushes
// the datapath with dummy pixels and presents the results in raster order under ready/valid handshakes.
module corner_win_sequencer #(
    parameter int imageW  = 200,
    parameter int imageH  = 200,
    parameter int pipeLat = 1,
    parameter int cntW    = 16
) (
    input  logic            pixClk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            out_ready,
    output logic            win_en,
    output logic            pix_zero,
    output logic            out_valid,
    output logic            out_mask,
    output logic [cntW-1:0] out_x,
    output logic [cntW-1:0] out_y,
    output logic            busy,
    output logic            frame_done
);

    // Datapath delay in window shifts: two window centres plus the adder-tree stages.
    localparam int D    = 2*imageW + 2 + pipeLat;
    localparam int NPIX = imageW * imageH;
    localparam int NTOT = NPIX + D;
    localparam int NW   = $clog2(NTOT + 1);

    localparam logic [NW-1:0]   N_LAST_PIX = NW'(NPIX - 1);
    localparam logic [NW-1:0]   N_LAST     = NW'(NTOT - 1);
    localparam logic [NW-1:0]   N_DELAY    = NW'(D);
    localparam logic [cntW-1:0] X_LAST     = cntW'(imageW - 1);
    localparam logic [cntW-1:0] X_HI       = cntW'(imageW - 3);
    localparam logic [cntW-1:0] Y_HI       = cntW'(imageH - 3);
    localparam logic [cntW-1:0] EDGE_LO    = cntW'(2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t          state;
    logic [NW-1:0]   n;
    logic [cntW-1:0] x_cnt;
    logic [cntW-1:0] y_cnt;
    logic            can_adv;
    logic            load_out;
    logic            next_mask;

    // The window may only shift when the output register is free or is being drained this cycle.
    assign can_adv = !out_valid || out_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        in_ready = 1'b0;
        win_en   = 1'b0;
        pix_zero = 1'b0;
        if (!rst) begin
            case (state)
                S_RUN: begin
                    in_ready = can_adv;
                    win_en   = in_valid && can_adv;
                end
                S_FLUSH: begin
                    win_en   = can_adv;
                    pix_zero = can_adv;
                end
                default: ;
            endcase
        end
    end

    // The first D shifts only prime the windows; every later shift yields one result.
    assign load_out  = win_en && (n >= N_DELAY);
    assign next_mask = (x_cnt < EDGE_LO) || (x_cnt > X_HI) ||
                       (y_cnt < EDGE_LO) || (y_cnt > Y_HI);

    assign busy = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pixClk) begin
        if (rst) begin
            state      <= S_IDLE;
            n          <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            out_valid  <= 1'b0;
            out_mask   <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        n     <= '0;
                        x_cnt <= '0;
                        y_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (win_en) begin
                        n <= n + 1'b1;
                        if (n == N_LAST_PIX) begin
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (win_en) begin
                        n <= n + 1'b1;
                        if (n == N_LAST) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (can_adv) begin
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Result register: a refill wins over the clear that acceptance would cause.
            if (load_out) begin
                out_valid <= 1'b1;
                out_x     <= x_cnt;
                out_y     <= y_cnt;
                out_mask  <= next_mask;
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_corner_win_sequencer.sv
// Self-checking bench for corner_win_sequencer at 8x6, pipeLat=1 (D=19): raster-order model,
// per-cycle handshake rules, stall stability, reset abort and ignored start requests.
`timescale 1ns/1ps
module tb_corner_win_sequencer;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int L    = 1;
    localparam int CW   = 16;
    localparam int DLY  = 2*W + 2 + L;
    localparam int NPIX = W * H;

    logic          pixClk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_ready = 1'b1;
    logic          win_en;
    logic          pix_zero;
    logic          out_valid;
    logic          out_mask;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic          busy;
    logic          frame_done;

    corner_win_sequencer #(.imageW(W), .imageH(H), .pipeLat(L), .cntW(CW)) dut (
        .pixClk(pixClk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .win_en(win_en), .pix_zero(pix_zero), .out_valid(out_valid),
        .out_mask(out_mask), .out_x(out_x), .out_y(out_y), .busy(busy), .frame_done(frame_done)
    );

    always #5 pixClk = ~pixClk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input int actual, input int expected);
        vec_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor statistics, cleared on request by the stimulus process.
    logic clr_req = 1'b0;
    int   pulses, zeros, hs, acc, unmasked, fd, first_pulses;
    int   acc_x[NPIX], acc_y[NPIX], acc_m[NPIX];
    logic have_prev;
    logic prev_v, prev_r, prev_m;
    int   prev_x, prev_y;

    function automatic int model_mask(input int x, input int y);
        return ((x < 2) || (x > W-3) || (y < 2) || (y > H-3)) ? 1 : 0;
    endfunction

    always @(negedge pixClk) begin
        if (clr_req || rst) begin
            if (clr_req) begin
                pulses = 0; zeros = 0; hs = 0; acc = 0; unmasked = 0; fd = 0; first_pulses = -1;
            end
            have_prev = 1'b0;
        end else begin
            if (out_valid && first_pulses < 0) first_pulses = pulses;
            if (win_en) begin
                if (pix_zero) check("dummy_while_ready", int'(in_ready), 0);
                else          check("shift_is_handshake", int'(in_valid && in_ready), 1);
                if (out_valid) check("shift_during_stall", int'(out_ready), 1);
                pulses++;
                if (pix_zero) zeros++;
            end else if (in_valid && in_ready) begin
                check("handshake_without_shift", 0, 1);
            end
            if (in_valid && in_ready) hs++;
            if (have_prev && prev_v && !prev_r) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_x", int'(out_x), prev_x);
                check("stall_y", int'(out_y), prev_y);
                check("stall_mask", int'(out_mask), int'(prev_m));
            end
            if (out_valid && out_ready) begin
                if (acc < NPIX) begin
                    check("out_x", int'(out_x), acc % W);
                    check("out_y", int'(out_y), acc / W);
                    check("out_mask", int'(out_mask), model_mask(acc % W, acc / W));
                    acc_x[acc] = int'(out_x);
                    acc_y[acc] = int'(out_y);
                    acc_m[acc] = int'(out_mask);
                end else begin
                    check("extra_output", acc, NPIX - 1);
                end
                if (!out_mask) unmasked++;
                acc++;
            end
            if (frame_done) begin
                fd++;
                check("done_busy", int'(busy), 0);
                check("done_after_all_out", acc, NPIX);
            end
            prev_v = out_valid; prev_r = out_ready; prev_m = out_mask;
            prev_x = int'(out_x); prev_y = int'(out_y);
            have_prev = 1'b1;
        end
    end

    task automatic clear_stats();
        clr_req = 1'b1;
        @(negedge pixClk);
        #1 clr_req = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_win_en"}, int'(win_en), 0);
        check({tag, "_pix_zero"}, int'(pix_zero), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_mask"}, int'(out_mask), 0);
        check({tag, "_out_x"}, int'(out_x), 0);
        check({tag, "_out_y"}, int'(out_y), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    // mode 0: free-running, 1: out_ready toggles, 2: in_valid low every third cycle,
    // 3: like 0 with extra start pulses inside RUN and FLUSH.
    task automatic drive(input int mode, input int cyc);
        start     = (cyc == 0) || (mode == 3 && (cyc == 10 || cyc == 60));
        in_valid  = (mode == 2) ? (cyc % 3 != 2) : 1'b1;
        out_ready = (mode == 1) ? cyc[0] : 1'b1;
    endtask

    task automatic run_frame(input int mode, input string tag);
        int cyc;
        clear_stats();
        cyc = 0;
        @(posedge pixClk); #1 drive(mode, cyc);
        while (fd == 0 && cyc < 2000) begin
            cyc++;
            @(posedge pixClk); #1 drive(mode, cyc);
        end
        check({tag, "_timeout"}, int'(cyc < 2000), 1);
        start = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge pixClk);
        @(negedge pixClk);
        check({tag, "_handshakes"}, hs, NPIX);
        check({tag, "_dummies"}, zeros, DLY);
        check({tag, "_pulses"}, pulses, NPIX + DLY);
        check({tag, "_outputs"}, acc, NPIX);
        check({tag, "_unmasked"}, unmasked, 8);
        check({tag, "_done_pulses"}, fd, 1);
        check({tag, "_first_valid_after"}, first_pulses, DLY + 1);
        check({tag, "_busy_after"}, int'(busy), 0);
        // Hand-computed samples: k=0 -> (0,0) border, k=18 -> (2,2) interior, k=29 -> (5,3)
        // interior, k=47 -> (7,5) border.
        check({tag, "_k0"}, acc_x[0] + 10*acc_y[0] + 100*acc_m[0], 100);
        check({tag, "_k18"}, acc_x[18] + 10*acc_y[18] + 100*acc_m[18], 22);
        check({tag, "_k29"}, acc_x[29] + 10*acc_y[29] + 100*acc_m[29], 35);
        check({tag, "_k47"}, acc_x[47] + 10*acc_y[47] + 100*acc_m[47], 157);
    endtask

    initial begin
        int guard;
        clear_stats();
        repeat (2) @(posedge pixClk);
        @(negedge pixClk);
        check_idle_outputs("reset");
        #1 rst = 1'b0;

        // start together with rst must not leave IDLE
        @(posedge pixClk); #1 rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        @(posedge pixClk); #1 rst = 1'b0; start = 1'b0;
        @(negedge pixClk);
        check("start_rst_busy", int'(busy), 0);
        repeat (3) @(posedge pixClk);
        @(negedge pixClk);
        check("start_rst_busy_later", int'(busy), 0);
        check("start_rst_in_ready", int'(in_ready), 0);

        run_frame(0, "plain");
        run_frame(1, "toggle_ready");
        run_frame(2, "gapped_valid");
        run_frame(3, "extra_start");

        // Abort mid-frame after 30 accepted pixels
        clear_stats();
        @(posedge pixClk); #1 drive(0, 0);
        guard = 0;
        while (hs < 30 && guard < 500) begin
            guard++;
            @(posedge pixClk); #1 drive(0, guard);
        end
        check("abort_reached_30", hs, 30);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge pixClk); #1 rst = 1'b0;
        @(negedge pixClk);
        check_idle_outputs("abort");
        repeat (6) @(posedge pixClk);
        @(negedge pixClk);
        check("abort_no_done", fd, 0);
        check("abort_idle", int'(busy), 0);

        run_frame(0, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/corner_win_sequencer.md
CORNER_WIN_SEQUENCER -- requirements
Module: corner_win_sequencer

Interface
REQ-001 Parameter imageW, default 200, pixels per line.
REQ-002 Parameter imageH, default 200, lines per frame.
REQ-003 Parameter pipeLat, default 1, registered stages after the corner window (adder trees); 0 is legal.
REQ-004 Parameter cntW, default 16, width of coordinate outputs.
REQ-005 pixClk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle frame start request.
REQ-008 in_valid  in  1  source pixel present.
REQ-009 in_ready  out  1  controller accepts pixel this cycle.
REQ-010 out_ready  in  1  sink accepts current output.
REQ-011 win_en  out  1  shift enable for the sobel window, the corner window and the adder-tree en_p.
REQ-012 pix_zero  out  1  force the datapath input pixel to 0 (flush dummy).
REQ-013 out_valid  out  1  datapath result for (out_x,out_y) is valid.
REQ-014 out_mask  out  1  result is a border pixel; sink writes 0.
REQ-015 out_x, out_y  out  cntW  raster coordinates of the current result.
REQ-016 busy  out  1  frame in progress.
REQ-017 frame_done  out  1  one-cycle pulse at frame completion.

Function
REQ-018 Datapath delay D SHALL be 2*imageW+2+pipeLat win_en pulses (two 3x3 window centres plus pipeLat).
REQ-019 States SHALL be IDLE, RUN, FLUSH and DRAIN, held in a registered FSM.
REQ-020 IDLE: busy=0; start -> RUN, clearing all counters; in_valid ignored.
REQ-021 RUN: in_ready = !out_valid | out_ready; a handshake (in_valid & in_ready) SHALL assert win_en in the same cycle with pix_zero=0.
REQ-022 RUN -> FLUSH on the handshake of pixel imageW*imageH.
REQ-023 FLUSH: in_ready=0; win_en=pix_zero=(!out_valid | out_ready) until D dummy pulses are issued; the last pulse -> DRAIN.
REQ-024 DRAIN: no win_en; when out_valid=0 or (out_valid & out_ready), -> IDLE with frame_done=1 for exactly that cycle.
REQ-025 Issue counter n (pulses issued before this one) SHALL count all win_en pulses, 0..imageW*imageH+D-1.
REQ-026 A win_en with n>=D SHALL set out_valid at the next edge, with sample index k=n-D, out_x=k mod imageW and out_y=k div imageW.
REQ-027 Coordinates SHALL be kept as x/y wrap counters, not division; x wraps at imageW-1 and increments y.
REQ-028 out_valid and its coordinates SHALL hold stable while out_ready=0, and SHALL clear after acceptance unless refilled in the same cycle.
REQ-029 out_mask=1 iff out_x<2, out_x>imageW-3, out_y<2 or out_y>imageH-3; registered with the coordinates.
REQ-030 Exactly imageW*imageH out_valid acceptances SHALL occur per frame, in strict raster order.
REQ-031 start in any state other than IDLE SHALL be ignored.
REQ-032 busy=1 in RUN, FLUSH and DRAIN.
REQ-033 imageW<5 or imageH<5 is unsupported.

Reset
REQ-034 rst SHALL force IDLE and clear all counters, in_ready, win_en, pix_zero, out_valid, out_mask, out_x, out_y, busy and frame_done to 0 at the next edge.
REQ-035 rst SHALL override start and any handshake in the same cycle.
REQ-036 rst mid-frame SHALL abort the frame with no frame_done pulse.

Verification (imageW=8, imageH=6, pipeLat=1, so D=19)
REQ-037 start, in_valid=1, out_ready=1 -> 48 input handshakes, 19 pix_zero pulses, 67 win_en total; first out_valid one cycle after the 20th win_en with (0,0) and mask=1; 48 outputs; 8 with mask=0 (x 2..5, y 2..3); one frame_done.
REQ-038 out_ready toggled 1/0 every cycle -> no lost or duplicated outputs; out_x/out_y/out_mask stable while stalled; win_en never fires while out_valid=1 and out_ready=0.
REQ-039 in_valid=0 on every third cycle -> win_en count and output sequence identical to REQ-037; only timing stretches.
REQ-040 rst after 30 accepted pixels -> all outputs 0 next cycle, no frame_done; a following start yields a complete correct frame.
REQ-041 start pulsed during RUN and FLUSH -> ignored; start asserted with rst -> remains IDLE, busy=0.
